// File: rtl/mux_8_pkg.sv
// Shared constants for the registered 8:1 multiplexer and its users.
// Control logic that drives the select should use the named codes below.
package mux_8_pkg;

    localparam int MUX8_SEL_W          = 3;
    localparam int MUX8_DATA_W_DEFAULT = 64;

    typedef logic [MUX8_SEL_W-1:0] mux8_sel_t;

    localparam mux8_sel_t SEL_IN0 = 3'd0;
    localparam mux8_sel_t SEL_IN1 = 3'd1;
    localparam mux8_sel_t SEL_IN2 = 3'd2;
    localparam mux8_sel_t SEL_IN3 = 3'd3;
    localparam mux8_sel_t SEL_IN4 = 3'd4;
    localparam mux8_sel_t SEL_IN5 = 3'd5;
    localparam mux8_sel_t SEL_IN6 = 3'd6;
    localparam mux8_sel_t SEL_IN7 = 3'd7;

endpackage

// File: rtl/mux_8_comb.sv
// Pure combinational 8:1 selector.
// All eight select codes are legal; an unknown select yields an unknown result.
module mux_8_comb
    import mux_8_pkg::*;
#(
    parameter int DATA_WIDTH = MUX8_DATA_W_DEFAULT
) (
    input  logic [MUX8_SEL_W-1:0] sel,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [DATA_WIDTH-1:0] in4,
    input  logic [DATA_WIDTH-1:0] in5,
    input  logic [DATA_WIDTH-1:0] in6,
    input  logic [DATA_WIDTH-1:0] in7,
    output logic [DATA_WIDTH-1:0] sel_data
);

    // The X default only matters when sel is X/Z; it keeps in0 from being
    // silently substituted in that case.
    always_comb begin
        sel_data = 'x;
        case (sel)
            SEL_IN0: sel_data = in0;
            SEL_IN1: sel_data = in1;
            SEL_IN2: sel_data = in2;
            SEL_IN3: sel_data = in3;
            SEL_IN4: sel_data = in4;
            SEL_IN5: sel_data = in5;
            SEL_IN6: sel_data = in6;
            SEL_IN7: sel_data = in7;
        endcase
    end

endmodule

// File: rtl/mux_8.sv
// Registered 8:1 multiplexer: selected input appears on out one clock later.
// The output register clears asynchronously while rst_n is low.
module mux_8
    import mux_8_pkg::*;
#(
    parameter int DATA_WIDTH = MUX8_DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [DATA_WIDTH-1:0] in4,
    input  logic [DATA_WIDTH-1:0] in5,
    input  logic [DATA_WIDTH-1:0] in6,
    input  logic [DATA_WIDTH-1:0] in7,
    input  logic [MUX8_SEL_W-1:0] sel,
    output logic [DATA_WIDTH-1:0] out
);

    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] out_q;

    mux_8_comb #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_comb (
        .sel      (sel),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .in5      (in5),
        .in6      (in6),
        .in7      (in7),
        .sel_data (out_d)
    );

    // No enable: the register reloads on every edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mux_8.sv
// Self-checking bench for mux_8 at the default 64-bit width and at 8 bits.
// Expected values come from indexing the bench's own input arrays by sel.
module tb_mux_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_w [8];
    logic [2:0]  sel;
    logic [63:0] out_w;
    logic [7:0]  in_n [8];
    logic [2:0]  sel_n;
    logic [7:0]  out_n;

    int checks = 0;
    int fails  = 0;

    logic [63:0] exp_w;
    logic [7:0]  exp_n;

    always #5 clk = ~clk;

    mux_8 dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (in_w[0]),
        .in1   (in_w[1]),
        .in2   (in_w[2]),
        .in3   (in_w[3]),
        .in4   (in_w[4]),
        .in5   (in_w[5]),
        .in6   (in_w[6]),
        .in7   (in_w[7]),
        .sel   (sel),
        .out   (out_w)
    );

    mux_8 #(.DATA_WIDTH(8)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (in_n[0]),
        .in1   (in_n[1]),
        .in2   (in_n[2]),
        .in3   (in_n[3]),
        .in4   (in_n[4]),
        .in5   (in_n[5]),
        .in6   (in_n[6]),
        .in7   (in_n[7]),
        .sel   (sel_n),
        .out   (out_n)
    );

    task automatic check_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 3'd1;
        sel_n = 3'd1;
        for (int k = 0; k < 8; k++) begin
            in_w[k] = 64'(k);
            in_n[k] = 8'hA0 + 8'(k);
        end
        #1;
        check_w("reset_initial", out_w, 64'h0);
        check_n("reset_initial_n", out_n, 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_w("reset_held", out_w, 64'h0);
        end

        // Release between edges; first edge afterwards loads in1.
        #2;
        rst_n = 1'b1;
        #1;
        check_w("release_no_edge", out_w, 64'h0);
        tick();
        check_w("release_first_edge", out_w, 64'h1);
        check_n("release_first_edge_n", out_n, 8'hA1);

        for (int s = 0; s < 8; s++) begin
            sel   = 3'(s);
            sel_n = 3'(s);
            exp_w = in_w[s];
            exp_n = in_n[s];
            tick();
            check_w("sweep", out_w, exp_w);
            check_n("sweep_n", out_n, exp_n);
        end

        sel = 3'd5;
        tick();
        check_w("latency_before", out_w, 64'h5);
        in_w[5] = 64'hDEAD_BEEF_0123_4567;
        #2;
        check_w("latency_not_comb", out_w, 64'h5);
        tick();
        check_w("latency_after", out_w, 64'hDEAD_BEEF_0123_4567);
        in_w[5] = 64'h5;

        sel   = 3'd7;
        sel_n = 3'd7;
        tick();
        check_w("pre_async", out_w, 64'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check_w("async_clear", out_w, 64'h0);
        check_n("async_clear_n", out_n, 8'h0);
        tick();
        check_w("async_held", out_w, 64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check_w("async_release_no_edge", out_w, 64'h0);
        tick();
        check_w("async_release_edge", out_w, 64'h7);
        check_n("async_release_edge_n", out_n, 8'hA7);

        sel = 3'd3;
        for (int k = 0; k < 8; k++) in_w[k] = 64'h0;
        in_w[3] = '1;
        tick();
        check_w("isolation_zero", out_w, '1);
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (k != 3) in_w[k] = {$urandom, $urandom};
            end
            tick();
            check_w("isolation_random", out_w, '1);
        end

        // Random back-to-back selections on both widths.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 8; k++) begin
                in_w[k] = {$urandom, $urandom};
                in_n[k] = 8'($urandom);
            end
            sel   = 3'($urandom_range(0, 7));
            sel_n = 3'($urandom_range(0, 7));
            exp_w = in_w[sel];
            exp_n = in_n[sel_n];
            tick();
            check_w("random", out_w, exp_w);
            check_n("random_n", out_n, exp_n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mux_8.md
Name: mux_8

Overview:
- Registered 8-to-1 data multiplexer.
- Selects one of eight equal-width data inputs by a 3-bit select and presents it on a registered output one clock after sampling.
- Generic datapath steering block, e.g. for choosing among eight candidate operands or results in the MCU pipeline (PC sources, writeback sources).

Parameters:
- DATA_WIDTH, default 64, width in bits of every data input and of the output; any value >= 1 is legal.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  DATA_WIDTH  data candidate, selected when sel = 3'd0.
- in1  input  DATA_WIDTH  data candidate, selected when sel = 3'd1.
- in2  input  DATA_WIDTH  data candidate, selected when sel = 3'd2.
- in3  input  DATA_WIDTH  data candidate, selected when sel = 3'd3.
- in4  input  DATA_WIDTH  data candidate, selected when sel = 3'd4.
- in5  input  DATA_WIDTH  data candidate, selected when sel = 3'd5.
- in6  input  DATA_WIDTH  data candidate, selected when sel = 3'd6.
- in7  input  DATA_WIDTH  data candidate, selected when sel = 3'd7.
- sel  input  3  select code, binary encoded.
- out  output  DATA_WIDTH  registered selected data.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - While rst_n = 0, out = {DATA_WIDTH{1'b0}} immediately, independent of clk.
  - Deassertion takes effect at the next rising clk edge with rst_n = 1.
- Selection is a purely combinational decode of sel:
  - 0 -> in0, 1 -> in1, ..., 7 -> in7.
  - All 8 codes are legal, so there is no default/out-of-range case.
  - If sel contains X/Z in simulation, the next out value is X; never silently substitute in0.
- Register:
  - On each rising clk edge with rst_n = 1, out <= input addressed by sel.
  - Latency is exactly 1 cycle from the sel/data sampling edge to out.
  - No enable: the register loads every cycle.
- Throughput: one new selection per cycle; back-to-back sel changes each appear on out one cycle later in order.
- Width rule: out is bit-exact copy of the selected input; no sign or zero extension, no truncation.
- Simultaneous events:
  - Input data and sel changing in the same cycle: the values present at the edge are used.
  - Reset asserted mid-stream: out clears immediately and the pending selection is discarded.
- No handshake, no backpressure, no internal state besides the out register.

Decomposition:
- Shared package holds:
  - MUX8_SEL_W = 3 constant.
  - Named select encodings (SEL_IN0..SEL_IN7 = 3'd0..3'd7) for use by instantiating control logic.
  - Default DATA_WIDTH constant = 64.
- One natural sub-module: mux_8_comb, the pure combinational 8:1 selector (case on sel).
  - mux_8 wraps mux_8_comb with the async-reset output register.

Test Plan:
- Reset: hold rst_n = 0 with in0..in7 = 64'h0..64'h7 and sel = 3'd1, toggle clk -> out = 64'h0 throughout; then release rst_n -> out = 64'h1 after the first rising edge.
- Full sweep: in_k = 64'h0..64'h7 (in_k = k), step sel 0..7 once per cycle -> out shows 64'h0..64'h7, each one cycle after its sel value.
- Latency/data change: sel = 3'd5 steady, change in5 from 64'h5 to 64'hDEAD_BEEF_0123_4567 -> out updates on the following rising edge only, not combinationally.
- Async reset mid-operation: out = 64'h7 (sel = 7), drive rst_n low between edges -> out = 0 immediately, before any clk edge; it stays 0 until reset release plus one edge.
- Isolation: sel = 3'd3, in3 = 64'hFFFF_FFFF_FFFF_FFFF, all other inputs 0 and then randomized each cycle -> out stays all-ones.
- Parameterization: DATA_WIDTH = 8, sweep sel with in_k = 8'hA0 + k -> out = 8'hA0..8'hA7 with 1-cycle latency.
